// File: rtl/ext_pipe.sv
// Registered immediate extender with a valid/ready handshake and a two-entry skid buffer.
// The extended value (not the raw immediate) is captured on accept; illegal modes yield zero plus an error flag.
module ext_pipe #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IMM_W-1:0]  in_imm_i,
    input  logic [2:0]        in_eop_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_ext_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              out_err_o
);

    localparam int HI_SHIFT = DATA_W - IMM_W;

    logic [DATA_W-1:0] sext, zext, new_ext;
    logic              new_err;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_ext_q, main_ext_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;
    logic              main_err_q, main_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_ext_q, skid_ext_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic              skid_err_q, skid_err_d;

    logic accept, consume;

    assign sext = DATA_W'($signed(in_imm_i));
    assign zext = DATA_W'(in_imm_i);

    always_comb begin
        new_ext = '0;
        new_err = 1'b0;
        case (in_eop_i)
            3'd0:    new_ext = sext;
            3'd1:    new_ext = zext;
            3'd2:    new_ext = zext << HI_SHIFT;
            3'd3:    new_ext = sext << BR_SHIFT;
            3'd4:    new_ext = zext << BR_SHIFT;
            default: new_err = 1'b1;
        endcase
    end

    // The skid entry only exists while main is stalled, so its state alone decides readiness.
    assign in_ready_o = !skid_valid_q;
    assign accept     = in_valid_i && !skid_valid_q && !flush_i;
    assign consume    = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ext_d   = main_ext_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_ext_d   = skid_ext_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                main_ext_d   = skid_ext_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || consume) begin
            main_valid_d = accept;
            if (accept) begin
                main_ext_d = new_ext;
                main_tag_d = in_tag_i;
                main_err_d = new_err;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ext_d   = new_ext;
            skid_tag_d   = in_tag_i;
            skid_err_d   = new_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            main_ext_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_ext_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ext_q   <= main_ext_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_ext_q   <= skid_ext_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_ext_o   = main_ext_q;
    assign out_tag_o   = main_tag_q;
    assign out_err_o   = main_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: the driver publishes the expected result with each stimulus,
// the negedge monitor tracks buffer occupancy at transaction level and compares every presented entry.
module tb_ext_pipe;

    typedef struct {
        logic [31:0] ext;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_imm;
    logic [2:0]  in_eop;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_ext;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_err;
    logic [7:0]  s_in_imm;
    logic [2:0]  s_in_eop;
    logic [4:0]  s_in_tag, s_out_tag;
    logic [15:0] s_out_ext;

    exp_t drv_exp;
    exp_t model_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ext_pipe dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_imm_i(in_imm), .in_eop_i(in_eop), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ext_o(out_ext), .out_tag_o(out_tag), .out_err_o(out_err)
    );

    ext_pipe #(.IMM_W(8), .DATA_W(16), .BR_SHIFT(1), .TAG_W(5)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_imm_i(s_in_imm), .in_eop_i(s_in_eop), .in_tag_i(s_in_tag),
        .out_valid_o(s_out_valid), .out_ready_i(1'b1),
        .out_ext_o(s_out_ext), .out_tag_o(s_out_tag), .out_err_o(s_out_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference extension done with plain integer arithmetic modulo 2**DATA_W.
    function automatic exp_t refModel(input int immW, input int dataW, input int brShift,
                                      input longint imm, input int mode, input logic [4:0] tag);
        exp_t   e;
        longint m = 64'd1 << dataW;
        longint s = (imm >= (64'd1 << (immW - 1))) ? imm - (64'd1 << immW) : imm;
        longint v;
        e.err = 1'b0;
        case (mode)
            0: v = s;
            1: v = imm;
            2: v = imm * (64'd1 << (dataW - immW));
            3: v = s * (64'd1 << brShift);
            4: v = imm * (64'd1 << brShift);
            default: begin v = 0; e.err = 1'b1; end
        endcase
        v = ((v % m) + m) % m;
        e.ext = v[31:0];
        e.tag = tag;
        return e;
    endfunction

    // Monitor: compares the presented entry against the queue head, then advances the model over the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit readyModel = (model_q.size() < 2);
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, readyModel});
            if (out_valid && model_q.size() > 0) begin
                checkOutput("out_ext", out_ext, model_q[0].ext);
                checkOutput("out_tag", {27'd0, out_tag}, {27'd0, model_q[0].tag});
                checkOutput("out_err", {31'd0, out_err}, {31'd0, model_q[0].err});
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
                if (in_valid && readyModel) model_q.push_back(drv_exp);
            end
        end
    end

    // Drives one cycle of stimulus, publishing the expected result alongside it.
    task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                                 input logic [4:0] tag, input logic rdy, input logic fl,
                                 input logic [31:0] wantExt, input logic wantErr);
        in_valid    = v;
        in_imm      = imm;
        in_eop      = mode;
        in_tag      = tag;
        out_ready   = rdy;
        flush       = fl;
        drv_exp.ext = wantExt;
        drv_exp.tag = tag;
        drv_exp.err = wantErr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 16'h0, 3'd0, 5'd0, rdy, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic smallCheck(input logic [7:0] imm, input logic [2:0] mode, input logic [15:0] want);
        s_in_valid = 1'b1;
        s_in_imm   = imm;
        s_in_eop   = mode;
        s_in_tag   = 5'd3;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checkOutput("small_valid", {31'd0, s_out_valid}, 32'd1);
        checkOutput("small_ext", {16'd0, s_out_ext}, {16'd0, want});
        checkOutput("small_err", {31'd0, s_out_err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_imm = 0; in_eop = 0; in_tag = 0; out_ready = 1; flush = 0;
        drv_exp = '{ext: 32'h0, tag: 5'h0, err: 1'b0};
        s_in_valid = 0; s_in_imm = 0; s_in_eop = 0; s_in_tag = 0;
        #12;
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_ext", out_ext, 32'd0);
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mode sweep, back-to-back with downstream always ready.
        applyStimulus(1, 16'h8001, 3'd0, 5'd1, 1, 0, 32'hFFFF8001, 0);
        applyStimulus(1, 16'h8001, 3'd1, 5'd2, 1, 0, 32'h00008001, 0);
        applyStimulus(1, 16'h1234, 3'd2, 5'd3, 1, 0, 32'h12340000, 0);
        applyStimulus(1, 16'hFFFF, 3'd3, 5'd4, 1, 0, 32'hFFFFFFFC, 0);
        applyStimulus(1, 16'h8000, 3'd4, 5'd5, 1, 0, 32'h00020000, 0);
        applyStimulus(1, 16'hABCD, 3'd6, 5'd7, 1, 0, 32'h00000000, 1);
        applyStimulus(1, 16'h0001, 3'd0, 5'd8, 1, 0, 32'h00000001, 0);
        idle(1);
        idle(1);

        // Backpressure: A to main, B to skid, C held upstream until the skid drains.
        applyStimulus(1, 16'h0010, 3'd1, 5'd10, 0, 0, 32'h10, 0);
        applyStimulus(1, 16'h0020, 3'd1, 5'd11, 0, 0, 32'h20, 0);
        applyStimulus(1, 16'h0030, 3'd1, 5'd12, 0, 0, 32'h30, 0);
        applyStimulus(1, 16'h0030, 3'd1, 5'd12, 0, 0, 32'h30, 0);
        checkOutput("stall_ext", out_ext, 32'h10);
        applyStimulus(1, 16'h0030, 3'd1, 5'd12, 1, 0, 32'h30, 0);
        applyStimulus(1, 16'h0030, 3'd1, 5'd12, 1, 0, 32'h30, 0);
        idle(1);
        idle(1);

        // Flush with both entries full and an input offered, then with only main full.
        applyStimulus(1, 16'h0041, 3'd1, 5'd13, 0, 0, 32'h41, 0);
        applyStimulus(1, 16'h0042, 3'd1, 5'd14, 0, 0, 32'h42, 0);
        applyStimulus(1, 16'h0043, 3'd1, 5'd15, 0, 1, 32'h43, 0);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1, 16'h0051, 3'd1, 5'd16, 0, 0, 32'h51, 0);
        applyStimulus(1, 16'h0052, 3'd1, 5'd17, 1, 1, 32'h52, 0);
        idle(1);
        applyStimulus(1, 16'h0061, 3'd1, 5'd18, 1, 0, 32'h61, 0);
        idle(1);

        // Asynchronous reset between edges while an entry is presented.
        applyStimulus(1, 16'hFFFF, 3'd3, 5'd19, 0, 0, 32'hFFFFFFFC, 0);
        idle(0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("areset_ext", out_ext, 32'd0);
        checkOutput("areset_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 16'h7FFF, 3'd0, 5'd20, 1, 0, 32'h00007FFF, 0);
        checkOutput("post_reset_ext", out_ext, 32'h00007FFF);
        idle(1);

        // Randomized traffic against the arithmetic reference.
        for (int i = 0; i < 400; i++) begin
            automatic logic [15:0] imm  = 16'($urandom_range(0, 65535));
            automatic logic [2:0]  mode = 3'($urandom_range(0, 7));
            automatic logic [4:0]  tag  = 5'($urandom_range(0, 31));
            automatic exp_t        e    = refModel(16, 32, 2, longint'(imm), int'(mode), tag);
            applyStimulus($urandom_range(0, 3) != 0, imm, mode, tag, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 31) == 0, e.ext, e.err);
        end
        for (int i = 0; i < 4; i++) idle(1);

        // Narrow build: 8-bit immediate into 16 bits with a one-bit branch shift.
        smallCheck(8'h80, 3'd3, 16'hFF00);
        smallCheck(8'hC3, 3'd2, 16'hC300);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
